lsu_pipe: RTL
=============

LSU_PIPE -- requirements
Module: lsu_pipe

Interface
REQ-001 SHALL have the following ports; one clock; reset is asynchronous and active-low:
  cpu_clk_i  in  1  sole clock
  cpu_rstn_i  in  1  asynchronous active-low reset
  flush_i  in  1  pipeline flush
  lsu_vld_i  in  1  request valid from scheduler
  lsu_rob_i  in  6  ROB tag
  lsu_op_i  in  4  {store, funct3}
  lsu_addr_i  in  32  effective address
  lsu_data_i  in  32  store data
  lsu_dest_i  in  6  load destination PRF
  lsu_busy_o  out  1  cannot accept
  store_commit_i  in  1  oldest uncommitted store retired
  store_buffer_empty_o  out  1  store queue empty
  dc_ld_req_o  out  1  load request to D-cache
  dc_ld_addr_o  out  32  word-aligned load address
  dc_ld_ack_i  in  1  load data valid
  dc_ld_data_i  in  32  load word
  dc_st_req_o  out  1  store request
  dc_st_addr_o  out  32  word-aligned store address
  dc_st_data_o  out  32  store data, lane-aligned
  dc_st_be_o  out  4  byte enables
  dc_st_ack_i  in  1  store accepted
  wb_valid_o  out  1  load writeback
  wb_dest_o  out  6  writeback PRF
  wb_data_o  out  32  extended load data
  completion_valid_o  out  1  ROB completion
  completed_rob_o  out  6  completing tag
  exception_o  out  1  misalignment exception
  exception_code_o  out  4  cause
  exception_rob_o  out  6  excepting tag

Function
REQ-002 SHALL accept a request in any cycle where lsu_vld_i=1 and lsu_busy_o=0; at most one per cycle.
REQ-003 SHALL drive lsu_busy_o=1, combinationally, when any of: load FSM not IDLE; store queue full (4 entries), even if popping that cycle; store completion pending.
REQ-004 SHALL decode funct3: 000 byte, 001 half, 010 word, 100 byte-unsigned, 101 half-unsigned; misaligned = half with addr[0]=1, or word with addr[1:0]!=0.
REQ-005 SHALL, on a misaligned request, pulse exception_o for one cycle the cycle after acceptance. Code: 4 for a load, 6 for a store. Tag = request ROB. No queue or FSM update and no completion.
REQ-006 SHALL enqueue an aligned store into a 4-entry circular queue (2-bit pointers plus wrap bit), storing word address, lane-shifted data, byte enables and committed=0.
REQ-007 SHALL signal store completion the cycle after acceptance. If a load writeback occupies that cycle, the store completion SHALL be held in a 1-entry pending register and issued the next free cycle.
REQ-008 SHALL, on store_commit_i, set committed on the oldest uncommitted entry; store_commit_i with no uncommitted entry is ignored.
REQ-009 SHALL hold dc_st_req_o high while the head entry is committed, and pop the head on dc_st_ack_i; address, data and byte enables stay stable while requested.
REQ-010 SHALL use load FSM states IDLE, WAIT_SQ, REQ, DRAIN.
  - IDLE: accepted aligned load with any queue entry at the same word address goes to WAIT_SQ; otherwise goes to REQ.
  - WAIT_SQ: goes to REQ once no matching entry remains.
  - REQ: dc_ld_req_o=1 until dc_ld_ack_i, then IDLE.
REQ-011 SHALL, on ack in REQ, assert wb_valid_o and completion_valid_o the next cycle; data is byte/half selected by addr[1:0], sign- or zero-extended per funct3. Latency is 1 cycle after ack, ack no earlier than the cycle after acceptance.
REQ-012 SHALL, on flush_i:
  - discard all uncommitted entries (tail set to first uncommitted slot) and retain committed ones;
  - clear pending store completion and suppress all outputs that cycle;
  - in REQ, move to DRAIN, wait for dc_ld_ack_i without writeback, then go to IDLE;
  - in WAIT_SQ, go to IDLE.
REQ-013 SHALL ignore lsu_vld_i during a flush_i cycle.
REQ-014 SHALL drive store_buffer_empty_o=1 when head==tail including the wrap bit.
REQ-015 SHALL give flush_i priority over store_commit_i when both occur in the same cycle; commit is applied first, then uncommitted entries are discarded.

Reset
REQ-016 SHALL, while cpu_rstn_i=0: empty the queue, put the FSM in IDLE, clear pending, and hold every output at 0 except store_buffer_empty_o=1.
REQ-017 SHALL abandon any outstanding D-cache transaction on reset.

Configuration
REQ-018 With LSU_STORE_FWD_EN defined, a load whose youngest same-word entry's byte enables cover all load bytes SHALL skip WAIT_SQ and the D-cache, writing back the forwarded data the cycle after acceptance. Without the macro, every word match SHALL go through WAIT_SQ.

Verification
REQ-019 Load of a word at 0x100, ack 3 cycles later with data 0x8badf00d -> wb_valid_o, wb_data_o=0x8badf00d, completed_rob_o=tag, 1 cycle after ack.
REQ-020 lbu at 0x103 with ack data 0x80000000 -> wb_data_o=0x00000080; lb same address -> 0xFFFFFF80.
REQ-021 Word store at 0x102 -> exception_o, code 6, queue unchanged, no completion.
REQ-022 Four stores with no commit -> lsu_busy_o=1; flush_i -> queue empty and store_buffer_empty_o=1.
REQ-023 Store word 0x11223344 to 0x200, then a load from 0x200 -> with LSU_STORE_FWD_EN, wb 0x11223344 next cycle; without it, load waits until commit and dc_st_ack_i, then issues.
REQ-024 Flush while in REQ, ack 2 cycles later -> no wb_valid_o, FSM returns to IDLE, and the next load completes normally.

Source files
------------

// File: rtl/lsu_pipe_if.sv
// Bundles the lsu_pipe request, commit, D-cache and completion signals.
// slave: the lsu_pipe side. master: the scheduler/ROB/D-cache side, or a testbench.
// Port names match the block's pin list, so the _i/_o suffixes are relative to lsu_pipe.
interface lsu_pipe_if;
  logic        flush_i;
  logic        lsu_vld_i;
  logic [5:0]  lsu_rob_i;
  logic [3:0]  lsu_op_i;
  logic [31:0] lsu_addr_i;
  logic [31:0] lsu_data_i;
  logic [5:0]  lsu_dest_i;
  logic        lsu_busy_o;
  logic        store_commit_i;
  logic        store_buffer_empty_o;
  logic        dc_ld_req_o;
  logic [31:0] dc_ld_addr_o;
  logic        dc_ld_ack_i;
  logic [31:0] dc_ld_data_i;
  logic        dc_st_req_o;
  logic [31:0] dc_st_addr_o;
  logic [31:0] dc_st_data_o;
  logic [3:0]  dc_st_be_o;
  logic        dc_st_ack_i;
  logic        wb_valid_o;
  logic [5:0]  wb_dest_o;
  logic [31:0] wb_data_o;
  logic        completion_valid_o;
  logic [5:0]  completed_rob_o;
  logic        exception_o;
  logic [3:0]  exception_code_o;
  logic [5:0]  exception_rob_o;

  modport slave (
    input  flush_i, lsu_vld_i, lsu_rob_i, lsu_op_i, lsu_addr_i, lsu_data_i, lsu_dest_i,
           store_commit_i, dc_ld_ack_i, dc_ld_data_i, dc_st_ack_i,
    output lsu_busy_o, store_buffer_empty_o, dc_ld_req_o, dc_ld_addr_o,
           dc_st_req_o, dc_st_addr_o, dc_st_data_o, dc_st_be_o,
           wb_valid_o, wb_dest_o, wb_data_o, completion_valid_o, completed_rob_o,
           exception_o, exception_code_o, exception_rob_o
  );

  modport master (
    output flush_i, lsu_vld_i, lsu_rob_i, lsu_op_i, lsu_addr_i, lsu_data_i, lsu_dest_i,
           store_commit_i, dc_ld_ack_i, dc_ld_data_i, dc_st_ack_i,
    input  lsu_busy_o, store_buffer_empty_o, dc_ld_req_o, dc_ld_addr_o,
           dc_st_req_o, dc_st_addr_o, dc_st_data_o, dc_st_be_o,
           wb_valid_o, wb_dest_o, wb_data_o, completion_valid_o, completed_rob_o,
           exception_o, exception_code_o, exception_rob_o
  );
endinterface

// File: rtl/lsu_pipe.sv
// Load/store unit: 4-entry in-order store queue with commit tracking, and a single-load FSM.
// Latency: store completion and misalignment exception 1 cycle after acceptance; load writeback 1 cycle after D-cache ack.
// Backpressure: lsu_busy_o (comb) while a load is in flight, the store queue is full, or a store completion is pending.
// Ports: cpu_clk_i clock, cpu_rstn_i async active-low reset, lsu (lsu_pipe_if.slave) carries all other signals.
// Optional: define LSU_STORE_FWD_EN to forward fully covered store data to a younger load.
module lsu_pipe (
  input  logic      cpu_clk_i,
  input  logic      cpu_rstn_i,
  lsu_pipe_if.slave lsu
);

  typedef enum logic [1:0] {IDLE, WAIT_SQ, REQ, DRAIN} ld_state_e;

  ld_state_e ld_state, ld_state_nxt;

  // ---------------- request decode ----------------
  function automatic logic [3:0] be_of(input logic [1:0] sz, input logic [1:0] ofs);
    case (sz)
      2'b00:   be_of = 4'b0001 << ofs;
      2'b01:   be_of = 4'b0011 << ofs;
      default: be_of = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_data(input logic [1:0] sz, input logic [1:0] ofs,
                                            input logic [31:0] d);
    case (sz)
      2'b00:   lane_data = {24'd0, d[7:0]} << {ofs, 3'b000};
      2'b01:   lane_data = {16'd0, d[15:0]} << {ofs, 3'b000};
      default: lane_data = d;
    endcase
  endfunction

  // funct3[2] selects zero extension for byte/half loads.
  function automatic logic [31:0] ld_extract(input logic [2:0] f3, input logic [1:0] ofs,
                                             input logic [31:0] w);
    logic [31:0] sh;
    sh = w >> {ofs, 3'b000};
    case (f3[1:0])
      2'b00:   ld_extract = {{24{sh[7] & ~f3[2]}}, sh[7:0]};
      2'b01:   ld_extract = {{16{sh[15] & ~f3[2]}}, sh[15:0]};
      default: ld_extract = w;
    endcase
  endfunction

  logic        req_store;
  logic [2:0]  req_f3;
  logic [1:0]  req_ofs;
  logic        req_misal;
  logic [3:0]  req_be;
  logic        lsu_busy;
  logic        acc, acc_ld, acc_st, acc_exc, acc_fwd;

  assign req_store = lsu.lsu_op_i[3];
  assign req_f3    = lsu.lsu_op_i[2:0];
  assign req_ofs   = lsu.lsu_addr_i[1:0];
  assign req_misal = (req_f3[1:0] == 2'b01 && req_ofs[0]) || (req_f3[1] && req_ofs != 2'b00);
  assign req_be    = be_of(req_f3[1:0], req_ofs);

  assign acc     = lsu.lsu_vld_i && !lsu_busy && !lsu.flush_i;
  assign acc_exc = acc && req_misal;
  assign acc_st  = acc && !req_misal && req_store;
  assign acc_ld  = acc && !req_misal && !req_store;

  // ---------------- store queue ----------------
  logic [29:0] sq_addr [4];
  logic [31:0] sq_data [4];
  logic [3:0]  sq_be   [4];
  logic [3:0]  sq_cmt;
  logic [2:0]  sq_head, sq_tail, sq_cptr, sq_cptr_nxt;  // cptr = oldest uncommitted entry
  logic [2:0]  sq_cnt;
  logic        sq_full, sq_empty, commit_do, st_req, st_pop;
  logic [1:0]  rel [4];
  logic [3:0]  sq_vld, sq_hit;
  logic        any_hit;
  logic [31:0] ld_addr;
  logic [29:0] chk_addr;

  assign sq_cnt      = sq_tail - sq_head;
  assign sq_full     = sq_cnt[2];
  assign sq_empty    = (sq_head == sq_tail);
  assign commit_do   = lsu.store_commit_i && (sq_cptr != sq_tail);
  assign sq_cptr_nxt = sq_cptr + {2'b00, commit_do};
  assign st_req      = !sq_empty && sq_cmt[sq_head[1:0]];
  assign st_pop      = st_req && lsu.dc_st_ack_i;

  // In IDLE the incoming request is checked; in WAIT_SQ the parked load is re-checked.
  assign chk_addr = (ld_state == IDLE) ? lsu.lsu_addr_i[31:2] : ld_addr[31:2];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      rel[i]    = 2'(i) - sq_head[1:0];
      sq_vld[i] = ({1'b0, rel[i]} < sq_cnt);
      sq_hit[i] = sq_vld[i] && (sq_addr[i] == chk_addr);
    end
  end
  assign any_hit = |sq_hit;

`ifdef LSU_STORE_FWD_EN
  logic [1:0] fwd_idx;
  logic       fwd_hit, fwd_ok;
  // Walk oldest to youngest so the last hit is the youngest same-word store.
  always_comb begin
    fwd_idx = sq_head[1:0];
    fwd_hit = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (sq_hit[sq_head[1:0] + 2'(k)]) begin
        fwd_idx = sq_head[1:0] + 2'(k);
        fwd_hit = 1'b1;
      end
    end
  end
  assign fwd_ok = fwd_hit && ((sq_be[fwd_idx] & req_be) == req_be);
  assign acc_fwd = acc_ld && fwd_ok;
`else
  assign acc_fwd = 1'b0;
`endif

  always_ff @(posedge cpu_clk_i or negedge cpu_rstn_i) begin
    if (!cpu_rstn_i) begin
      sq_head <= '0;
      sq_tail <= '0;
      sq_cptr <= '0;
      sq_cmt  <= '0;
    end else begin
      if (commit_do) sq_cmt[sq_cptr[1:0]] <= 1'b1;
      sq_cptr <= sq_cptr_nxt;
      if (st_pop) sq_head <= sq_head + 3'd1;
      // Commit lands first, then everything younger than the commit point is dropped.
      if (lsu.flush_i) begin
        sq_tail <= sq_cptr_nxt;
      end else if (acc_st) begin
        sq_cmt[sq_tail[1:0]] <= 1'b0;
        sq_tail <= sq_tail + 3'd1;
      end
    end
  end

  // Payload only matters for valid entries, so it carries no reset.
  always_ff @(posedge cpu_clk_i) begin
    if (acc_st) begin
      sq_addr[sq_tail[1:0]] <= lsu.lsu_addr_i[31:2];
      sq_data[sq_tail[1:0]] <= lane_data(req_f3[1:0], req_ofs, lsu.lsu_data_i);
      sq_be[sq_tail[1:0]]   <= req_be;
    end
  end

  // ---------------- load FSM ----------------
  logic [2:0] ld_f3;
  logic [5:0] ld_rob, ld_dest;
  logic       ld_req, ld_done_wb;

  always_ff @(posedge cpu_clk_i or negedge cpu_rstn_i) begin
    if (!cpu_rstn_i) ld_state <= IDLE;
    else             ld_state <= ld_state_nxt;
  end

  always_comb begin
    ld_state_nxt = ld_state;
    case (ld_state)
      IDLE:    if (acc_ld && !acc_fwd) ld_state_nxt = any_hit ? WAIT_SQ : REQ;
      WAIT_SQ: if (lsu.flush_i) ld_state_nxt = IDLE;
               else if (!any_hit) ld_state_nxt = REQ;
      // An ack coinciding with flush closes the transaction outright.
      REQ:     if (lsu.dc_ld_ack_i) ld_state_nxt = IDLE;
               else if (lsu.flush_i) ld_state_nxt = DRAIN;
      DRAIN:   if (lsu.dc_ld_ack_i) ld_state_nxt = IDLE;
      default: ld_state_nxt = IDLE;
    endcase
  end

  // The D-cache request stays up through DRAIN so the outstanding access can still be acked.
  always_comb begin
    ld_req     = (ld_state == REQ) || (ld_state == DRAIN);
    ld_done_wb = (ld_state == REQ) && lsu.dc_ld_ack_i && !lsu.flush_i;
  end

  always_ff @(posedge cpu_clk_i or negedge cpu_rstn_i) begin
    if (!cpu_rstn_i) begin
      ld_addr <= '0;
      ld_f3   <= '0;
      ld_rob  <= '0;
      ld_dest <= '0;
    end else if (acc_ld) begin
      ld_addr <= lsu.lsu_addr_i;
      ld_f3   <= req_f3;
      ld_rob  <= lsu.lsu_rob_i;
      ld_dest <= lsu.lsu_dest_i;
    end
  end

  // ---------------- writeback / completion / exception ----------------
  logic        wb_vld_q, cmp_vld_q, exc_vld_q, pend_vld_q;
  logic [5:0]  wb_dest_q, cmp_rob_q, exc_rob_q, pend_rob_q;
  logic [31:0] wb_data_q;
  logic [3:0]  exc_code_q;
  logic        st_src_vld;
  logic [5:0]  st_src_rob;

  assign st_src_vld = pend_vld_q || acc_st;
  assign st_src_rob = pend_vld_q ? pend_rob_q : lsu.lsu_rob_i;

  always_ff @(posedge cpu_clk_i or negedge cpu_rstn_i) begin
    if (!cpu_rstn_i) begin
      wb_vld_q   <= 1'b0;
      wb_dest_q  <= '0;
      wb_data_q  <= '0;
      cmp_vld_q  <= 1'b0;
      cmp_rob_q  <= '0;
      exc_vld_q  <= 1'b0;
      exc_code_q <= '0;
      exc_rob_q  <= '0;
      pend_vld_q <= 1'b0;
      pend_rob_q <= '0;
    end else if (lsu.flush_i) begin
      wb_vld_q   <= 1'b0;
      cmp_vld_q  <= 1'b0;
      exc_vld_q  <= 1'b0;
      pend_vld_q <= 1'b0;
    end else begin
      exc_vld_q <= acc_exc;
      if (acc_exc) begin
        exc_code_q <= req_store ? 4'd6 : 4'd4;
        exc_rob_q  <= lsu.lsu_rob_i;
      end
      // A load writeback owns the completion port; a colliding store completion is parked.
      if (ld_done_wb || acc_fwd) begin
        wb_vld_q   <= 1'b1;
        cmp_vld_q  <= 1'b1;
        wb_dest_q  <= ld_done_wb ? ld_dest : lsu.lsu_dest_i;
        cmp_rob_q  <= ld_done_wb ? ld_rob : lsu.lsu_rob_i;
`ifdef LSU_STORE_FWD_EN
        wb_data_q  <= ld_done_wb ? ld_extract(ld_f3, ld_addr[1:0], lsu.dc_ld_data_i)
                                 : ld_extract(req_f3, req_ofs, sq_data[fwd_idx]);
`else
        wb_data_q  <= ld_extract(ld_f3, ld_addr[1:0], lsu.dc_ld_data_i);
`endif
        pend_vld_q <= st_src_vld;
        pend_rob_q <= st_src_rob;
      end else begin
        wb_vld_q   <= 1'b0;
        cmp_vld_q  <= st_src_vld;
        cmp_rob_q  <= st_src_rob;
        pend_vld_q <= 1'b0;
      end
    end
  end

  // ---------------- outputs ----------------
  assign lsu_busy = (ld_state != IDLE) || sq_full || pend_vld_q;

  assign lsu.lsu_busy_o           = lsu_busy;
  assign lsu.store_buffer_empty_o = sq_empty;
  assign lsu.dc_ld_req_o          = ld_req;
  assign lsu.dc_ld_addr_o         = ld_req ? {ld_addr[31:2], 2'b00} : 32'd0;
  assign lsu.dc_st_req_o          = st_req;
  assign lsu.dc_st_addr_o         = st_req ? {sq_addr[sq_head[1:0]], 2'b00} : 32'd0;
  assign lsu.dc_st_data_o         = st_req ? sq_data[sq_head[1:0]] : 32'd0;
  assign lsu.dc_st_be_o           = st_req ? sq_be[sq_head[1:0]] : 4'd0;
  assign lsu.wb_valid_o           = wb_vld_q && !lsu.flush_i;
  assign lsu.wb_dest_o            = wb_dest_q;
  assign lsu.wb_data_o            = wb_data_q;
  assign lsu.completion_valid_o   = cmp_vld_q && !lsu.flush_i;
  assign lsu.completed_rob_o      = cmp_rob_q;
  assign lsu.exception_o          = exc_vld_q && !lsu.flush_i;
  assign lsu.exception_code_o     = exc_code_q;
  assign lsu.exception_rob_o      = exc_rob_q;

endmodule
